// File: rtl/mod47_pkg.sv
// Shared mod-47 residue definitions: field widths, scaling constants,
// FSM state type, result payload and the one-step modular add.
package mod47_pkg;

    localparam int unsigned M     = 47;
    localparam int unsigned W     = 6;
    localparam int unsigned FWD_C = 34;
    localparam int unsigned INV_C = 18;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic         err;
        logic [W-1:0] data;
    } res_t;

    // (a + b) with one conditional subtract; exact whenever a + b < 2M
    function automatic logic [W-1:0] mod_add_reduce(input logic [W-1:0] a,
                                                    input logic [W-1:0] b);
        logic [W:0] s;
        s = (W+1)'(a) + (W+1)'(b);
        if (s >= (W+1)'(M)) begin
            s = s - (W+1)'(M);
        end
        return W'(s);
    endfunction

endpackage

// File: rtl/mod47_const_unscale_seq_if.sv
// Input and output valid/ready channels of the mod-47 unscaler.
interface mod47_const_unscale_seq_if;
    import mod47_pkg::*;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         out_err;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_err
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_err
    );

endinterface

// File: rtl/mod47_const_unscale_seq_step.sv
// One MSB-first multiply step: acc_next = (2*acc + bit*y) mod M.
module mod_dbl_add_step
    import mod47_pkg::*;
(
    input  logic [W-1:0] i_acc,
    input  logic [W-1:0] i_y,
    input  logic         i_bit,
    output logic [W-1:0] o_acc_next_c
);

    logic [W-1:0] w_dbl;

    always_comb begin
        w_dbl        = mod_add_reduce(i_acc, i_acc);
        o_acc_next_c = i_bit ? mod_add_reduce(w_dbl, i_y) : w_dbl;
    end

endmodule

// File: rtl/mod47_const_unscale_seq.sv
// Bit-serial (x mod M) * C mod M with valid/ready on both sides; undoes
// the forward *34 scaling when C is its inverse (18).
module mod47_const_unscale_seq
    import mod47_pkg::*;
#(
    parameter int unsigned C  = INV_C,
    parameter int unsigned CW = 5
) (
    input  logic                        clk,
    input  logic                        rst,
    mod47_const_unscale_seq_if.slave    bus
);

    localparam int unsigned   IW     = (CW > 1) ? $clog2(CW) : 1;
    localparam logic [CW-1:0] C_BITS = CW'(C);

    generate
        if ((CW != $clog2(C + 1)) || (C == 0) || (C >= M)) begin : g_bad_param
            $error("mod47_const_unscale_seq: C must be in (0,M) and CW must equal $clog2(C+1)");
        end
    endgenerate

    state_t        r_state;
    state_t        w_state_next;
    logic [W-1:0]  r_y;
    logic [W-1:0]  r_acc;
    logic [W-1:0]  w_acc_next;
    logic [IW-1:0] r_idx;
    logic          r_err;
    logic          r_in_ready;
    logic          r_out_valid;
    res_t          r_res;
    logic          w_accept;
    logic          w_last;

    mod_dbl_add_step u_step (
        .i_acc        (r_acc),
        .i_y          (r_y),
        .i_bit        (C_BITS[r_idx]),
        .o_acc_next_c (w_acc_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_last       = (r_idx == '0);
        case (r_state)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_last) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Handshake flags track the next state so they are valid from the state's first cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_res       <= '0;
            r_acc       <= '0;
            r_idx       <= IW'(CW - 1);
            r_y         <= '0;
            r_err       <= 1'b0;
        end else begin
            r_in_ready  <= (w_state_next == ST_IDLE);
            r_out_valid <= (w_state_next == ST_DONE);
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_y   <= mod_add_reduce(bus.in_data, '0);
                        r_err <= (bus.in_data >= W'(M));
                        r_acc <= '0;
                        r_idx <= IW'(CW - 1);
                    end
                end
                ST_RUN: begin
                    r_acc <= w_acc_next;
                    if (w_last) begin
                        r_res.err  <= r_err;
                        r_res.data <= w_acc_next;
                    end else begin
                        r_idx <= r_idx - IW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_res.data;
    assign bus.out_err   = r_res.err;

endmodule

// File: tb/tb_mod47_const_unscale_seq.sv
// Self-checking bench for mod47_const_unscale_seq: scoreboard of expected
// results from an arithmetic model, one task per scenario.
module tb_mod47_const_unscale_seq;
    import mod47_pkg::*;

    localparam int unsigned CW  = 5;
    localparam int          LAT = CW + 1;
    localparam int          GAP = CW + 2;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mod47_const_unscale_seq_if bus ();

    mod47_const_unscale_seq #(.C(INV_C), .CW(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   n_total = 0;
    int   n_pass  = 0;
    res_t sb[$];

    function automatic res_t model(input logic [W-1:0] d);
        res_t        r;
        int unsigned y;
        y      = (int'(d) >= int'(M)) ? int'(d) - int'(M) : int'(d);
        r.err  = (int'(d) >= int'(M));
        r.data = W'((y * INV_C) % M);
        return r;
    endfunction

    // Drives one operation, pushes its expectation, returns what the DUT presented
    task automatic xfer(input logic [W-1:0] d, input int stall_pct,
                        output res_t got, output int lat,
                        output int unstable, output bit tmo);
        int k;
        tmo      = 1'b0;
        unstable = 0;
        bus.in_data   = d;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        k = 0;
        while (!bus.in_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!bus.in_ready) tmo = 1'b1;
        sb.push_back(model(d));
        @(negedge clk);
        lat = 1;
        bus.in_valid = 1'b0;
        while (!bus.out_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        if (!bus.out_valid) tmo = 1'b1;
        got.data = bus.out_data;
        got.err  = bus.out_err;
        k = 0;
        while (1) begin
            bus.out_ready = (k >= 20) || (int'($urandom_range(99)) >= stall_pct);
            @(negedge clk);
            k++;
            if (bus.out_ready) break;
            if (!bus.out_valid || bus.out_data !== got.data || bus.out_err !== got.err)
                unstable++;
        end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = 6'd34;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        n_total++;
        if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready);
        else n_pass++;
        n_total++;
        if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid);
        else n_pass++;
        n_total++;
        if (bus.out_data !== 6'd0 || bus.out_err !== 1'b0)
            $display("FAIL reset_out_data got=%0d/%b exp=0/0", bus.out_data, bus.out_err);
        else n_pass++;
        bus.in_valid = 1'b0;
        rst          = 1'b0;
        @(negedge clk);
        n_total++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0)
            $display("FAIL reset_no_accept in_ready=%b out_valid=%b exp=1/0", bus.in_ready, bus.out_valid);
        else n_pass++;
    endtask

    task automatic test_single();
        res_t got, exp;
        int   lat, unst;
        bit   tmo;
        xfer(6'd34, 0, got, lat, unst, tmo);
        exp = sb.pop_front();
        n_total++;
        if (tmo !== 1'b0) $display("FAIL single_timeout got=%b exp=0", tmo);
        else n_pass++;
        n_total++;
        if (lat != LAT) $display("FAIL single_latency got=%0d exp=%0d", lat, LAT);
        else n_pass++;
        n_total++;
        if (got.data !== exp.data || got.data !== 6'd1)
            $display("FAIL single_data got=%0d exp=%0d", got.data, exp.data);
        else n_pass++;
        n_total++;
        if (got.err !== 1'b0) $display("FAIL single_err got=%b exp=0", got.err);
        else n_pass++;
        n_total++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0)
            $display("FAIL single_return_idle in_ready=%b out_valid=%b exp=1/0", bus.in_ready, bus.out_valid);
        else n_pass++;
    endtask

    task automatic test_sweep();
        res_t got, exp;
        int   lat, unst, unst_sum, lat_bad, tmo_n;
        bit   tmo;
        unst_sum = 0;
        lat_bad  = 0;
        tmo_n    = 0;
        for (int y = 0; y < int'(M); y++) begin
            xfer(W'(y), 50, got, lat, unst, tmo);
            exp = sb.pop_front();
            unst_sum += unst;
            if (lat != LAT) lat_bad++;
            if (tmo) tmo_n++;
            n_total++;
            if (got.data !== exp.data || got.err !== exp.err)
                $display("FAIL sweep_data y=%0d got=%0d/%b exp=%0d/%b", y, got.data, got.err, exp.data, exp.err);
            else n_pass++;
            n_total++;
            if ((int'(got.data) * FWD_C) % M != y)
                $display("FAIL sweep_roundtrip y=%0d got=%0d exp=%0d", y, (int'(got.data) * FWD_C) % M, y);
            else n_pass++;
        end
        n_total++;
        if (unst_sum != 0) $display("FAIL sweep_stall_stability got=%0d changes exp=0", unst_sum);
        else n_pass++;
        n_total++;
        if (lat_bad != 0 || tmo_n != 0)
            $display("FAIL sweep_latency bad=%0d timeouts=%0d exp=0/0", lat_bad, tmo_n);
        else n_pass++;
    endtask

    task automatic test_out_of_range();
        res_t got, exp;
        int   lat, unst;
        bit   tmo;
        xfer(6'd47, 0, got, lat, unst, tmo);
        exp = sb.pop_front();
        n_total++;
        if (tmo || got.data !== exp.data || got.err !== exp.err || got.data !== 6'd0 || got.err !== 1'b1)
            $display("FAIL oor_47 got=%0d/%b exp=0/1", got.data, got.err);
        else n_pass++;
        xfer(6'd63, 0, got, lat, unst, tmo);
        exp = sb.pop_front();
        n_total++;
        if (tmo || got.data !== exp.data || got.err !== exp.err || got.data !== 6'd6 || got.err !== 1'b1)
            $display("FAIL oor_63 got=%0d/%b exp=6/1", got.data, got.err);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] vals[5] = '{6'd34, 6'd0, 6'd63, 6'd46, 6'd1};
        res_t exp;
        int   last_acc, gap_bad, overlap, got_n, idx, cyc;
        bit   acc_now;
        last_acc = -1;
        gap_bad  = 0;
        overlap  = 0;
        got_n    = 0;
        idx      = 0;
        cyc      = 0;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = vals[0];
        while (got_n < 5 && cyc < 200) begin
            if (bus.out_valid) begin
                n_total++;
                if (sb.size() == 0) begin
                    $display("FAIL b2b_unexpected_output got=%0d exp=none", bus.out_data);
                end else begin
                    exp = sb.pop_front();
                    if (bus.out_data !== exp.data || bus.out_err !== exp.err)
                        $display("FAIL b2b_data got=%0d/%b exp=%0d/%b", bus.out_data, bus.out_err, exp.data, exp.err);
                    else n_pass++;
                end
                got_n++;
            end
            if (bus.out_valid && bus.in_ready) overlap++;
            acc_now = bus.in_valid && bus.in_ready;
            if (acc_now) begin
                sb.push_back(model(bus.in_data));
                if (last_acc >= 0 && cyc - last_acc != GAP) gap_bad++;
                last_acc = cyc;
                idx++;
            end
            @(negedge clk);
            cyc++;
            if (acc_now) begin
                if (idx < 5) bus.in_data = vals[idx];
                else bus.in_valid = 1'b0;
            end
        end
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        n_total++;
        if (got_n != 5 || idx != 5 || sb.size() != 0)
            $display("FAIL b2b_count results=%0d accepts=%0d left=%0d exp=5/5/0", got_n, idx, sb.size());
        else n_pass++;
        n_total++;
        if (gap_bad != 0) $display("FAIL b2b_spacing bad_gaps=%0d exp=0", gap_bad);
        else n_pass++;
        n_total++;
        if (overlap != 0) $display("FAIL b2b_accept_while_emit got=%0d exp=0", overlap);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        res_t got, exp;
        int   lat, unst, k, bad;
        bit   tmo;
        bus.in_data  = 6'd34;
        bus.in_valid = 1'b1;
        k = 0;
        while (!bus.in_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_total++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_data !== 6'd0 || bus.out_err !== 1'b0)
            $display("FAIL midrst_state got=%b/%b/%0d/%b exp=1/0/0/0",
                     bus.in_ready, bus.out_valid, bus.out_data, bus.out_err);
        else n_pass++;
        bus.out_ready = 1'b1;
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b0) bad++;
        end
        bus.out_ready = 1'b0;
        n_total++;
        if (bad != 0) $display("FAIL midrst_ghost_output got=%0d cycles exp=0", bad);
        else n_pass++;
        xfer(6'd1, 0, got, lat, unst, tmo);
        exp = sb.pop_front();
        n_total++;
        if (tmo || got.data !== exp.data || got.data !== 6'd18)
            $display("FAIL midrst_next_op got=%0d exp=18", got.data);
        else n_pass++;
    endtask

    task automatic test_stall();
        res_t         exp;
        logic [W-1:0] od;
        int           k, bad;
        bus.in_data   = 6'd20;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        k = 0;
        while (!bus.in_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        sb.push_back(model(6'd20));
        @(negedge clk);
        bus.in_valid = 1'b0;
        k = 0;
        while (!bus.out_valid && k < 50) begin
            @(negedge clk);
            k++;
        end
        od           = bus.out_data;
        bus.in_valid = 1'b1;
        bus.in_data  = 6'd7;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_data !== od) bad++;
        end
        n_total++;
        if (bad != 0) $display("FAIL stall_hold got=%0d bad cycles exp=0", bad);
        else n_pass++;
        exp = sb.pop_front();
        n_total++;
        if (od !== exp.data || bus.out_err !== exp.err)
            $display("FAIL stall_data got=%0d/%b exp=%0d/%b", od, bus.out_err, exp.data, exp.err);
        else n_pass++;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        n_total++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0)
            $display("FAIL stall_release in_ready=%b out_valid=%b exp=1/0", bus.in_ready, bus.out_valid);
        else n_pass++;
        sb.push_back(model(6'd7));
        @(negedge clk);
        bus.in_valid = 1'b0;
        n_total++;
        if (bus.in_ready !== 1'b0) $display("FAIL stall_pending_accept in_ready=%b exp=0", bus.in_ready);
        else n_pass++;
        k = 0;
        while (!bus.out_valid && k < 50) begin
            @(negedge clk);
            k++;
        end
        exp = sb.pop_front();
        n_total++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== exp.data || bus.out_err !== exp.err)
            $display("FAIL stall_pending_data got=%0d/%b exp=%0d/%b", bus.out_data, bus.out_err, exp.data, exp.err);
        else n_pass++;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_sweep();
        test_out_of_range();
        test_back_to_back();
        test_reset_mid();
        test_stall();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not complete, passed=%0d total=%0d", n_pass, n_total);
        $fatal(1);
    end

endmodule
